// File: rtl/sprite_pkg.sv
// Shared definitions for the scanline sprite evaluator and the sprite fetcher:
// OAM word field positions, evaluator states and the line-buffer entry layout.
package sprite_pkg;

  localparam int OAM_EN_BIT    = 31;
  localparam int OAM_YFLIP_BIT = 30;
  localparam int OAM_XFLIP_BIT = 29;
  localparam int OAM_PRIO_BIT  = 28;
  localparam int OAM_YPOS_HI   = 27;
  localparam int OAM_YPOS_LO   = 18;
  localparam int OAM_XPOS_HI   = 17;
  localparam int OAM_XPOS_LO   = 8;
  localparam int OAM_REF_HI    = 7;
  localparam int OAM_REF_LO    = 0;

  localparam int DEF_ROW_W  = 5;
  localparam int DEF_ADDR_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Entry layout for the default geometry; valid sits in the LSB.
  typedef struct packed {
    logic [DEF_ROW_W-1:0]  row;
    logic [DEF_ADDR_W-1:0] oam_index;
    logic                  valid;
  } entry_t;

  function automatic int entry_width(input int row_w, input int addr_w);
    return row_w + addr_w + 1;
  endfunction

endpackage

// File: rtl/sprite_row_check.sv
// Vertical hit test for one object against one scanline, returning the
// row inside the sprite with y-flip applied. Purely combinational.
module sprite_row_check #(
  parameter int SPRITE_H = 16,
  parameter int ROW_W    = $clog2(2*SPRITE_H)
) (
  input  logic [9:0]       line_i,
  input  logic [9:0]       ypos_i,
  input  logic             enable_i,
  input  logic             yflip_i,
  input  logic             tall_i,
  output logic             hit_o,
  output logic [ROW_W-1:0] row_o
);

  localparam logic [10:0] H_NORM = 11'(SPRITE_H);
  localparam logic [10:0] H_TALL = 11'(2*SPRITE_H);

  logic signed [10:0] diff;
  logic        [10:0] height;
  logic        [10:0] row_full;
  logic               unused_row_bits;

  // A negative difference means the object starts below the line; no wrap.
  assign diff     = $signed({1'b0, line_i}) - $signed({1'b0, ypos_i});
  assign height   = tall_i ? H_TALL : H_NORM;
  assign hit_o    = enable_i && !diff[10] && ($unsigned(diff) < height);
  assign row_full = yflip_i ? (height - 11'd1 - $unsigned(diff)) : $unsigned(diff);
  assign row_o    = row_full[ROW_W-1:0];

  assign unused_row_bits = ^row_full[10:ROW_W];

endmodule

// File: rtl/sprite_line_evaluator.sv
// Scans OAM once per start pulse and collects up to MAX_PER_LINE objects that
// cover the captured scanline, flagging overflow when more objects hit.
module sprite_line_evaluator
  import sprite_pkg::*;
#(
  parameter int MAX_PER_LINE  = 32,
  parameter int OAM_OBJECTS   = 64,
  parameter int OAM_ADDR_SIZE = 6,
  parameter int SPRITE_H      = 16,
  parameter int ROW_W         = $clog2(2*SPRITE_H),
  parameter int ENTRY_W       = entry_width(ROW_W, OAM_ADDR_SIZE),
  parameter int CNT_W         = $clog2(MAX_PER_LINE+1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [9:0]                            line,
  input  logic                                  tall_mode,
  input  logic [31:0]                           oam_data,
  output logic [OAM_ADDR_SIZE-1:0]              oam_addr,
  output logic [MAX_PER_LINE-1:0][ENTRY_W-1:0]  buffer,
  output logic [CNT_W-1:0]                      count,
  output logic                                  overflow,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  line_prepared
);

  localparam logic [OAM_ADDR_SIZE-1:0] LAST_ADDR = OAM_ADDR_SIZE'(OAM_OBJECTS-1);
  localparam logic [CNT_W-1:0]         FULL_CNT  = CNT_W'(MAX_PER_LINE);

  state_e                              state_q;
  logic [9:0]                          line_q;
  logic                                tall_q;
  logic [OAM_ADDR_SIZE-1:0]            addr_q;
  logic                                issued_all_q;
  logic                                beat_valid_q;
  logic [OAM_ADDR_SIZE-1:0]            beat_addr_q;
  logic [MAX_PER_LINE-1:0][ENTRY_W-1:0] buffer_q;
  logic [CNT_W-1:0]                    count_q;
  logic [CNT_W-1:0]                    count_d;
  logic                                overflow_q;
  logic                                prepared_q;

  logic               obj_hit;
  logic [ROW_W-1:0]   obj_row;
  logic               eval;
  logic               buf_wr;
  logic               ovf_hit;
  logic               last_beat;
  logic               end_scan;
  logic [ENTRY_W-1:0] new_entry;
  logic               unused_fields;

  sprite_row_check #(
    .SPRITE_H (SPRITE_H),
    .ROW_W    (ROW_W)
  ) u_row_check (
    .line_i   (line_q),
    .ypos_i   (oam_data[OAM_YPOS_HI:OAM_YPOS_LO]),
    .enable_i (oam_data[OAM_EN_BIT]),
    .yflip_i  (oam_data[OAM_YFLIP_BIT]),
    .tall_i   (tall_q),
    .hit_o    (obj_hit),
    .row_o    (obj_row)
  );

  // x-flip, priority, xpos and spriteref belong to the fetcher.
  assign unused_fields = ^{oam_data[OAM_XFLIP_BIT], oam_data[OAM_PRIO_BIT],
                           oam_data[OAM_XPOS_HI:OAM_XPOS_LO],
                           oam_data[OAM_REF_HI:OAM_REF_LO]};

  always_comb begin
    eval      = (state_q == ST_SCAN) && beat_valid_q;
    buf_wr    = eval && obj_hit && (count_q != FULL_CNT);
    ovf_hit   = eval && obj_hit && (count_q == FULL_CNT);
    last_beat = eval && (beat_addr_q == LAST_ADDR);
    end_scan  = ovf_hit || last_beat;
    count_d   = count_q + CNT_W'(1);
    new_entry = {obj_row, beat_addr_q, 1'b1};
  end

  // Handshake: start is a one-cycle request accepted in any state; done is a
  // one-cycle completion pulse and line_prepared holds until the next start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      line_q       <= '0;
      tall_q       <= 1'b0;
      addr_q       <= '0;
      issued_all_q <= 1'b0;
      beat_valid_q <= 1'b0;
      beat_addr_q  <= '0;
      buffer_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      prepared_q   <= 1'b0;
    end else if (start) begin
      state_q      <= ST_SCAN;
      line_q       <= line;
      tall_q       <= tall_mode;
      addr_q       <= '0;
      issued_all_q <= 1'b0;
      beat_valid_q <= 1'b0;
      beat_addr_q  <= '0;
      buffer_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      prepared_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          // The read issued this cycle returns next cycle as beat_addr_q.
          if (!issued_all_q && !end_scan) begin
            beat_valid_q <= 1'b1;
            beat_addr_q  <= addr_q;
            if (addr_q == LAST_ADDR) begin
              issued_all_q <= 1'b1;
            end else begin
              addr_q <= addr_q + OAM_ADDR_SIZE'(1);
            end
          end else begin
            beat_valid_q <= 1'b0;
          end
          if (buf_wr) begin
            for (int i = 0; i < MAX_PER_LINE; i++) begin
              if (count_q == CNT_W'(i)) begin
                buffer_q[i] <= new_entry;
              end
            end
            count_q <= count_d;
          end
          if (ovf_hit) begin
            overflow_q <= 1'b1;
          end
          if (end_scan) begin
            state_q    <= ST_DONE;
            prepared_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          beat_valid_q <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          beat_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign oam_addr      = addr_q;
  assign buffer        = buffer_q;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q == ST_SCAN);
  assign done          = (state_q == ST_DONE);
  assign line_prepared = prepared_q;

endmodule

// File: tb/tb_sprite_line_evaluator.sv
// Directed bench for sprite_line_evaluator: single-object vector table plus
// hand-written sequences for multi-hit, overflow, restart and mid-scan reset.
module tb_sprite_line_evaluator;
  import sprite_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [9:0]            line;
  logic                  tall_mode;
  logic [31:0]           oam_data;
  logic [5:0]            oam_addr;
  logic [31:0][11:0]     buffer;
  logic [5:0]            count;
  logic                  overflow;
  logic                  busy;
  logic                  done;
  logic                  line_prepared;

  logic [31:0] oam_mem [64];

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      name;
    int         idx;
    logic       en;
    logic       yflip;
    logic [9:0] ypos;
    logic [9:0] ln;
    logic       tall;
    logic       exp_hit;
    logic [4:0] exp_row;
  } vec_t;

  vec_t vq[$];

  sprite_line_evaluator dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .line          (line),
    .tall_mode     (tall_mode),
    .oam_data      (oam_data),
    .oam_addr      (oam_addr),
    .buffer        (buffer),
    .count         (count),
    .overflow      (overflow),
    .busy          (busy),
    .done          (done),
    .line_prepared (line_prepared)
  );

  // Clock / reset block and OAM model with one-cycle read latency
  always #5 clk = ~clk;

  always @(posedge clk) oam_data <= oam_mem[oam_addr];

  function automatic logic [31:0] mk_obj(input logic en, input logic yf, input logic [9:0] ypos);
    return {en, yf, 2'b11, ypos, 10'h2AA, 8'h5A};
  endfunction

  function automatic logic [11:0] mk_entry(input logic [4:0] r, input int idx);
    entry_t e;
    e.row       = r;
    e.oam_index = 6'(idx);
    e.valid     = 1'b1;
    return e;
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_buf(input string name, input logic [383:0] act, input logic [383:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 64; i++) oam_mem[i] = 32'h0;
  endtask

  task automatic add_vec(input string name, input int idx, input logic en, input logic yf,
                         input int ypos, input int ln, input logic tall,
                         input logic hit, input int row);
    vec_t v;
    v.name = name; v.idx = idx; v.en = en; v.yflip = yf;
    v.ypos = 10'(ypos); v.ln = 10'(ln); v.tall = tall;
    v.exp_hit = hit; v.exp_row = 5'(row);
    vq.push_back(v);
  endtask

  // Driver: pulse start and count cycles until done (cycle of start = 0).
  task automatic run_scan(input logic [9:0] ln, input logic tl, output int done_cyc,
                          output logic c1_busy, output logic c1_prep,
                          output logic [5:0] c1_addr, output logic busy_at_done);
    @(negedge clk);
    line = ln; tall_mode = tl; start = 1'b1;
    done_cyc = -1; c1_busy = 1'b0; c1_prep = 1'b1; c1_addr = '1; busy_at_done = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        c1_busy = busy; c1_prep = line_prepared; c1_addr = oam_addr;
      end
      if (done) begin
        done_cyc = c; busy_at_done = busy;
        break;
      end
    end
  endtask

  initial begin
    int               dc;
    logic             b1, p1, bd;
    logic [5:0]       a1;
    logic [31:0][11:0] eb;
    int               seen;

    reset = 1'b1; start = 1'b0; line = '0; tall_mode = 1'b0;
    clear_oam();

    add_vec("disabled",     4,  1'b0, 1'b0, 100,  100,  1'b0, 1'b0, 0);
    add_vec("yflip_row12",  5,  1'b1, 1'b1, 100,  103,  1'b0, 1'b1, 12);
    add_vec("below_line",   6,  1'b1, 1'b0, 101,  100,  1'b0, 1'b0, 0);
    add_vec("diff15_hit",   7,  1'b1, 1'b0, 85,   100,  1'b0, 1'b1, 15);
    add_vec("diff16_miss",  8,  1'b1, 1'b0, 84,   100,  1'b0, 1'b0, 0);
    add_vec("line0_ypos0",  0,  1'b1, 1'b0, 0,    0,    1'b0, 1'b1, 0);
    add_vec("tall_row20",   3,  1'b1, 1'b0, 80,   100,  1'b1, 1'b1, 20);
    add_vec("tall_diff31",  9,  1'b1, 1'b0, 69,   100,  1'b1, 1'b1, 31);
    add_vec("tall_diff32",  9,  1'b1, 1'b0, 68,   100,  1'b1, 1'b0, 0);
    add_vec("tall_yflip",   2,  1'b1, 1'b1, 90,   100,  1'b1, 1'b1, 21);
    add_vec("last_index",   63, 1'b1, 1'b0, 500,  510,  1'b0, 1'b1, 10);
    add_vec("no_wrap",      1,  1'b1, 1'b0, 1000, 5,    1'b0, 1'b0, 0);
    add_vec("top_line",     0,  1'b1, 1'b1, 1020, 1023, 1'b0, 1'b1, 12);
    add_vec("yflip_diff0",  11, 1'b1, 1'b1, 200,  200,  1'b0, 1'b1, 15);

    // Reset state
    repeat (3) @(negedge clk);
    check_int("rst_addr",  int'(oam_addr), 0);
    check_buf("rst_buf",   buffer, '0);
    check_int("rst_count", int'(count), 0);
    check_int("rst_flags", int'({overflow, busy, done, line_prepared}), 0);
    reset = 1'b0;
    @(negedge clk);
    check_int("idle_flags", int'({busy, done, line_prepared}), 0);

    // Table-driven single-object vectors
    foreach (vq[i]) begin
      clear_oam();
      oam_mem[vq[i].idx] = mk_obj(vq[i].en, vq[i].yflip, vq[i].ypos);
      run_scan(vq[i].ln, vq[i].tall, dc, b1, p1, a1, bd);
      eb = '0;
      if (vq[i].exp_hit) eb[0] = mk_entry(vq[i].exp_row, vq[i].idx);
      check_int($sformatf("%s_latency", vq[i].name), dc, 66);
      check_int($sformatf("%s_count", vq[i].name), int'(count), vq[i].exp_hit ? 1 : 0);
      check_buf($sformatf("%s_buf", vq[i].name), buffer, eb);
      check_int($sformatf("%s_ovf", vq[i].name), int'(overflow), 0);
      check_int($sformatf("%s_c1", vq[i].name), int'({b1, p1, a1}), 128);
      check_int($sformatf("%s_done_flags", vq[i].name), int'({bd, line_prepared}), 1);
    end

    // Two hits, normal mode, then hold behaviour after done
    clear_oam();
    oam_mem[3]  = mk_obj(1'b1, 1'b0, 10'd90);
    oam_mem[10] = mk_obj(1'b1, 1'b0, 10'd90);
    run_scan(10'd100, 1'b0, dc, b1, p1, a1, bd);
    eb = '0;
    eb[0] = mk_entry(5'd10, 3);
    eb[1] = mk_entry(5'd10, 10);
    check_int("pair_latency", dc, 66);
    check_int("pair_count", int'(count), 2);
    check_buf("pair_buf", buffer, eb);
    repeat (3) @(negedge clk);
    check_int("pair_hold_addr", int'(oam_addr), 63);
    check_int("pair_hold_flags", int'({busy, done, line_prepared}), 1);
    check_int("pair_hold_count", int'(count), 2);

    // Overflow: 40 objects all on line 50
    clear_oam();
    for (int i = 0; i < 40; i++) oam_mem[i] = mk_obj(1'b1, 1'b0, 10'd50);
    run_scan(10'd50, 1'b0, dc, b1, p1, a1, bd);
    check_int("ovf_latency", dc, 35);
    check_int("ovf_count", int'(count), 32);
    check_int("ovf_flag", int'(overflow), 1);
    check_int("ovf_first", int'(buffer[0]), int'(mk_entry(5'd0, 0)));
    check_int("ovf_last", int'(buffer[31]), int'(mk_entry(5'd0, 31)));
    check_int("ovf_busy_at_done", int'(bd), 0);
    @(negedge clk);
    check_int("ovf_done_pulse", int'(done), 0);

    // Restart at T+20 with a new line; objects at ypos 90 on line 95
    clear_oam();
    oam_mem[3]  = mk_obj(1'b1, 1'b0, 10'd90);
    oam_mem[10] = mk_obj(1'b1, 1'b0, 10'd90);
    @(negedge clk);
    line = 10'd100; tall_mode = 1'b0; start = 1'b1;
    dc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        dc = c;
        break;
      end
      if (c == 20) begin
        line = 10'd95; start = 1'b1;
      end
    end
    eb = '0;
    eb[0] = mk_entry(5'd5, 3);
    eb[1] = mk_entry(5'd5, 10);
    check_int("restart_latency", dc, 86);
    check_int("restart_count", int'(count), 2);
    check_buf("restart_buf", buffer, eb);

    // Asynchronous reset at T+20 mid-scan
    @(negedge clk);
    line = 10'd100; tall_mode = 1'b0; start = 1'b1;
    repeat (20) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_int("prereset_count", int'(count), 2);
    reset = 1'b1;
    #1;
    check_int("areset_count", int'(count), 0);
    check_buf("areset_buf", buffer, '0);
    check_int("areset_addr", int'(oam_addr), 0);
    check_int("areset_flags", int'({overflow, busy, done, line_prepared}), 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check_int("areset_no_done", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_line_evaluator.md
# sprite_line_evaluator

Second-generation scanline sprite evaluator. On a start pulse it scans OAM for one target line and fills a buffer of up to MAX_PER_LINE entries. Each entry holds an OAM index and the row to fetch inside the sprite, with y-flip already applied. It sits between OAM (synchronous RAM, 1-cycle read latency) and the sprite pixel fetcher. It adds three features: per-frame 1×/2× sprite height mode, an explicit start/done handshake, and a sprite-overflow flag with hit count.

## Interface
Parameters:
- MAX_PER_LINE, 32: buffer depth, i.e. maximum sprites per line.
- OAM_OBJECTS, 64: number of objects scanned. Must be ≤ 2**OAM_ADDR_SIZE.
- OAM_ADDR_SIZE, 6: OAM address width.
- SPRITE_H, 16: base sprite height in lines (power of 2). Tall mode uses 2*SPRITE_H.
- ROW_W, $clog2(2*SPRITE_H): row field width.

Ports:
- clk  in  1: system clock. All logic is on the rising edge.
- reset  in  1: asynchronous, active-high reset.
- start  in  1: single-cycle pulse that begins evaluation of `line`.
- line  in  10: target scanline. Captured on start.
- tall_mode  in  1: 0 selects height SPRITE_H, 1 selects 2*SPRITE_H. Captured on start.
- oam_data  in  32: OAM word. Bit [31] enable, [30] y-flip, [29] x-flip, [28] priority, [27:18] ypos, [17:8] xpos, [7:0] spriteref.
- oam_addr  out  OAM_ADDR_SIZE: registered OAM read address.
- buffer  out  MAX_PER_LINE×(ROW_W+OAM_ADDR_SIZE+1): entry layout is {row, oam_index, valid}.
- count  out  $clog2(MAX_PER_LINE+1): number of valid entries.
- overflow  out  1: more than MAX_PER_LINE hits on the line.
- busy  out  1: high in the SCAN state.
- done  out  1: one-cycle pulse when the buffer is final.
- line_prepared  out  1: level signal. High from done until the next start.

## Operation
- States are IDLE, SCAN and DONE. Reset enters IDLE.
- IDLE --start--> SCAN. On that edge the block captures line and tall_mode, clears buffer/count/overflow to 0, sets scan index to 0 and drops line_prepared.
- SCAN: oam_addr advances by 1 per cycle, from 0 to OAM_OBJECTS-1. A pipeline valid bit tracks which data beat belongs to which address. The data for address a is evaluated in the cycle after oam_addr=a.
- Hit test:
  - diff = {1'b0,line} − {1'b0,ypos}, computed as 11-bit signed.
  - hit = enable && diff ≥ 0 && diff < H, where H is the captured height.
  - No vertical wrap-around: an object with ypos > line never hits.
- Row = y-flip ? H−1−diff : diff, truncated to ROW_W bits. In normal mode the row MSB is 0.
- On a hit with count < MAX_PER_LINE: buffer[count] ← {row, a, 1}, and count increments.
- On a hit with count == MAX_PER_LINE: overflow ← 1 and the block goes to DONE immediately. No further beats are evaluated.
- SCAN --last beat (a = OAM_OBJECTS-1) evaluated--> DONE.
- DONE lasts 1 cycle: done=1 and line_prepared set, then the block returns to IDLE. Buffer, count and overflow hold until the next start.
- A start received in SCAN or DONE restarts: the capture and clear rule above applies and the in-flight beat is discarded. A start in the same cycle as the overflow or last beat also wins.
- The x-flip, priority, xpos and spriteref fields are not interpreted here.

## Timing
- Reset values: oam_addr=0, buffer=0, count=0, overflow=0, busy=0, done=0, line_prepared=0.
- With start at cycle T:
  - busy is high from T+1.
  - oam_addr=k at cycle T+1+k.
  - Evaluation of object k happens at T+2+k. Its entry is visible in buffer at T+3+k.
  - Full scan: done is pulsed at T+OAM_OBJECTS+2. With the default parameters this is T+66.
  - busy is low in the done cycle.
- Overflow at beat k: done is pulsed at T+3+k.
- Reset asserted mid-scan clears all state asynchronously. No done pulse is produced.
- oam_addr holds OAM_OBJECTS-1 after the scan until the next start.

## Structure
- A shared package `sprite_pkg` holds:
  - the OAM bit-position localparams,
  - the state enum (IDLE, SCAN, DONE),
  - the entry struct type and the entry-width function.
- The combinational sub-module `sprite_row_check` takes (line, ypos, enable, yflip, tall, SPRITE_H) and returns hit and row. The fetcher will reuse it.

## Test plan
- Empty OAM (all enable=0), line=100: done at T+66, count=0, overflow=0, buffer all 0.
- Objects 3 and 10 at ypos=90, SPRITE_H=16, line=100:
  - normal mode: entries {10,3,1} and {10,10,1}.
  - tall_mode with ypos=80: row=20.
- Y-flip: object 5 at ypos=100, yflip=1, line=103, normal mode → row=12.
- 40 objects all hit line 50, MAX_PER_LINE=32: count=32, overflow=1, done at T+3+32.
- Boundaries:
  - ypos=101 on line 100 → no hit.
  - ypos=85 with diff=15 → hit; ypos=84 → no hit (normal mode).
  - ypos=0 on line=0 → row 0.
- Start reasserted at T+20, and separately reset at T+20: the scan restarts (done at T+86) / all outputs are zero with no done pulse.
